// File: rtl/adxl_spi_responder.sv
// ---------------------------------------------------------------------------
// adxl_spi_responder
//   SPI slave that mimics the register interface of an ADXL345-style
//   accelerometer over 3-wire, mode-3 SPI. The sensor front end (outside this
//   block) supplies X/Y/Z sample words and activity events; this block
//   exposes them through a register map and drives the INT2 pin.
//
// Ports
//   iSPI_CLK          system clock; every flop updates on its rising edge
//   iRSTN             asynchronous active-low reset
//   iSPI_SCLK         SPI clock from master (idles high)
//   iSPI_CSN          SPI chip select from master, active-low
//   SPI_SDIO          bidirectional data; driven only in the read data phase
//   iX/iY/iZ_DATA     16-bit sample words
//   iSAMPLE_STB       one-cycle pulse: new sample on iX/iY/iZ_DATA
//   iACT_STB          one-cycle pulse: activity event
//   oINT2             registered interrupt output
//   oMEASURE          registered copy of POWER_CTL[3]
// ---------------------------------------------------------------------------
module adxl_spi_responder #(
  parameter logic [7:0] DEVID_VAL   = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        iSPI_CLK,
  input  logic        iRSTN,
  input  logic        iSPI_SCLK,
  input  logic        iSPI_CSN,
  inout  wire         SPI_SDIO,
  input  logic [15:0] iX_DATA,
  input  logic [15:0] iY_DATA,
  input  logic [15:0] iZ_DATA,
  input  logic        iSAMPLE_STB,
  input  logic        iACT_STB,
  output logic        oINT2,
  output logic        oMEASURE
);

  localparam logic [5:0] ADDR_DEVID      = 6'h00;
  localparam logic [5:0] ADDR_CFG_LO     = 6'h1D;
  localparam logic [5:0] ADDR_CFG_HI     = 6'h31;
  localparam logic [5:0] ADDR_BW_RATE    = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL  = 6'h2D;
  localparam logic [5:0] ADDR_INT_ENABLE = 6'h2E;
  localparam logic [5:0] ADDR_INT_MAP    = 6'h2F;
  localparam logic [5:0] ADDR_INT_SOURCE = 6'h30;
  localparam logic [5:0] ADDR_DATAX0     = 6'h32;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  // ---------------- input synchronizers and SCLK edge detect ----------------
  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, sdio_sync;
  logic sclk_s, csn_s, sdio_s, sclk_d;
  logic sclk_rise, sclk_fall;
  logic armed;  // set once CSN has been seen high since reset

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign sdio_s    = sdio_sync[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s &  sclk_d;

  // CSN resets to "asserted" so that a frame already running when reset is
  // released cannot start the FSM; armed only sets after CSN is seen high.
  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      sclk_sync <= '1;
      csn_sync  <= '0;
      sdio_sync <= '0;
      sclk_d    <= 1'b1;
      armed     <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // stage samples the pre-edge value of the one before it.
      sclk_sync[0] <= iSPI_SCLK;
      csn_sync[0]  <= iSPI_CSN;
      sdio_sync[0] <= SPI_SDIO;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        csn_sync[i]  <= csn_sync[i-1];
        sdio_sync[i] <= sdio_sync[i-1];
      end
      sclk_d <= sclk_s;
      if (csn_s) armed <= 1'b1;
    end
  end

  // ---------------- frame FSM ----------------
  state_t     state_q, state_d;
  logic [2:0] bit_cnt;
  logic [6:0] shift_q;
  logic [7:0] rx_byte;
  logic       rw_q, mb_q;
  logic [5:0] addr_q;
  logic [7:0] tx_q;
  logic       sdio_oe;
  logic       in_frame, cmd_done, byte_done, load_bit;
  logic [7:0] rd_data;

  assign in_frame  = !csn_s && (state_q != ST_IDLE);
  assign rx_byte   = {shift_q, sdio_s};
  assign cmd_done  = in_frame && (state_q == ST_CMD)  && sclk_rise && (bit_cnt == 3'd7);
  assign byte_done = in_frame && (state_q == ST_DATA) && sclk_rise && (bit_cnt == 3'd7);
  assign load_bit  = in_frame && (state_q == ST_DATA) && rw_q && sclk_fall;

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!csn_s && armed) state_d = ST_CMD;
      ST_CMD:  if (csn_s) state_d = ST_IDLE;
               else if (cmd_done) state_d = ST_DATA;
      ST_DATA: if (csn_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q <= ST_IDLE;
      bit_cnt <= 3'd0;
      shift_q <= 7'd0;
      rw_q    <= 1'b0;
      mb_q    <= 1'b0;
      addr_q  <= 6'd0;
      tx_q    <= 8'd0;
      sdio_oe <= 1'b0;
    end else begin
      state_q <= state_d;
      // Bit counter restarts whenever the frame ends, so a partial byte is
      // simply forgotten.
      if (!in_frame) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        shift_q <= rx_byte[6:0];
      end
      if (cmd_done) begin
        rw_q   <= rx_byte[7];
        mb_q   <= rx_byte[6];
        addr_q <= rx_byte[5:0];
      end else if (byte_done && mb_q) begin
        addr_q <= addr_q + 6'd1;  // 6-bit wrap 0x3F -> 0x00
      end
      if (!in_frame || state_q != ST_DATA) sdio_oe <= 1'b0;
      else if (load_bit)                   sdio_oe <= 1'b1;
      // First falling edge of each byte loads a fresh byte; later ones shift.
      if (load_bit) tx_q <= (bit_cnt == 3'd0) ? rd_data : {tx_q[6:0], 1'b0};
    end
  end

  assign SPI_SDIO = sdio_oe ? tx_q[7] : 1'bz;

  // ---------------- register file and sample buffers ----------------
  logic [7:0]  cfg [29:49];  // 0x1D..0x31; slot 0x30 is never written
  logic [15:0] data_x, data_y, data_z;
  logic [15:0] pend_x, pend_y, pend_z;
  logic        pend_valid, data_ready, activity;
  logic [7:0]  int_source;
  logic        wr_ok, wr_en, copy_sample, sample_ok;

  assign wr_ok       = (addr_q >= ADDR_CFG_LO) && (addr_q <= ADDR_CFG_HI) &&
                       (addr_q != ADDR_INT_SOURCE);
  assign wr_en       = byte_done && !rw_q && wr_ok;
  assign sample_ok   = iSAMPLE_STB && cfg[ADDR_POWER_CTL][3];
  // Visible data only changes while CSN is high so a burst never mixes samples.
  assign copy_sample = pend_valid && csn_s;
  assign int_source  = {data_ready, 2'b00, activity, 4'b0000};

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      // NOTE: the configuration array is a handful of flops with defined
      // power-on values, so it is reset like any other register.
      for (int i = 29; i <= 49; i++) cfg[i] <= 8'h00;
      cfg[ADDR_BW_RATE] <= 8'h0A;
      data_x     <= 16'd0;
      data_y     <= 16'd0;
      data_z     <= 16'd0;
      pend_x     <= 16'd0;
      pend_y     <= 16'd0;
      pend_z     <= 16'd0;
      pend_valid <= 1'b0;
      data_ready <= 1'b0;
      activity   <= 1'b0;
      oINT2      <= 1'b0;
      oMEASURE   <= 1'b0;
    end else begin
      if (wr_en) cfg[addr_q] <= rx_byte;

      if (sample_ok) begin
        pend_x     <= iX_DATA;
        pend_y     <= iY_DATA;
        pend_z     <= iZ_DATA;
        pend_valid <= 1'b1;
      end else if (copy_sample) begin
        pend_valid <= 1'b0;
      end
      if (copy_sample) begin
        data_x <= pend_x;
        data_y <= pend_y;
        data_z <= pend_z;
      end

      // Read-clear happens only on a completed byte; sets take priority.
      if (copy_sample)
        data_ready <= 1'b1;
      else if (byte_done && rw_q && addr_q == ADDR_DATAX0)
        data_ready <= 1'b0;

      if (iACT_STB)
        activity <= 1'b1;
      else if (byte_done && rw_q && addr_q == ADDR_INT_SOURCE)
        activity <= 1'b0;

      oINT2    <= |(int_source & cfg[ADDR_INT_ENABLE] & cfg[ADDR_INT_MAP]);
      oMEASURE <= cfg[ADDR_POWER_CTL][3];
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    rd_data = 8'h00;
    if (addr_q == ADDR_DEVID) begin
      rd_data = DEVID_VAL;
    end else if (addr_q == ADDR_INT_SOURCE) begin
      rd_data = int_source;
    end else if (addr_q >= ADDR_CFG_LO && addr_q <= ADDR_CFG_HI) begin
      rd_data = cfg[addr_q];
    end else begin
      case (addr_q)
        6'h32:   rd_data = data_x[7:0];
        6'h33:   rd_data = data_x[15:8];
        6'h34:   rd_data = data_y[7:0];
        6'h35:   rd_data = data_y[15:8];
        6'h36:   rd_data = data_z[7:0];
        6'h37:   rd_data = data_z[15:8];
        default: rd_data = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_adxl_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_adxl_spi_responder
//   Directed bench: a mode-3, 3-wire SPI master built from tasks, plus
//   scenario tasks that compare DUT responses against hand-computed bytes.
// ---------------------------------------------------------------------------
module tb_adxl_spi_responder;

  localparam int H = 8;  // SCLK half-period in system clocks

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, csn;
  logic        tb_oe, tb_do;
  wire         sdio;
  logic [15:0] x_data, y_data, z_data;
  logic        sample_stb, act_stb;
  logic        int2, measure;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] wbuf [8];
  logic [7:0] rbuf [8];

  assign sdio = tb_oe ? tb_do : 1'bz;

  always #5 clk = ~clk;

  adxl_spi_responder #(.DEVID_VAL(8'hE5), .SYNC_STAGES(2)) dut (
    .iSPI_CLK   (clk),
    .iRSTN      (rst_n),
    .iSPI_SCLK  (sclk),
    .iSPI_CSN   (csn),
    .SPI_SDIO   (sdio),
    .iX_DATA    (x_data),
    .iY_DATA    (y_data),
    .iZ_DATA    (z_data),
    .iSAMPLE_STB(sample_stb),
    .iACT_STB   (act_stb),
    .oINT2      (int2),
    .oMEASURE   (measure)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: time %0t exceeded bound", $time);
    $fatal(1, "bench did not complete");
  end

  // ---------------- SPI master primitives ----------------
  task automatic spi_bit(input logic drive, input logic v, output logic d);
    sclk  = 1'b0;
    tb_oe = drive;
    tb_do = v;
    repeat (H) @(negedge clk);
    d    = sdio;
    sclk = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic spi_start();
    csn = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic spi_cmd(input logic [7:0] cmd);
    logic d;
    for (int i = 7; i >= 0; i--) spi_bit(1'b1, cmd[i], d);
    tb_oe = 1'b0;
  endtask

  task automatic spi_data(input logic rd, input int nbits);
    logic d;
    for (int k = 0; k < nbits; k++) begin
      spi_bit(!rd, wbuf[k/8][7-(k%8)], d);
      rbuf[k/8][7-(k%8)] = d;
    end
  endtask

  task automatic spi_stop();
    tb_oe = 1'b0;
    repeat (H) @(negedge clk);
    csn = 1'b1;
    repeat (3*H) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input int nbits);
    spi_start();
    spi_cmd(cmd);
    spi_data(cmd[7], nbits);
    spi_stop();
  endtask

  task automatic spi_write(input logic [5:0] addr, input logic [7:0] v);
    wbuf[0] = v;
    spi_frame({2'b00, addr}, 8);
  endtask

  task automatic spi_read(input logic [5:0] addr, output logic [7:0] v);
    spi_frame({2'b10, addr}, 8);
    v = rbuf[0];
  endtask

  // Drives 1 then 0 onto SDIO; a released line follows the bench both times.
  task automatic probe_z(output logic [1:0] obs);
    tb_oe = 1'b1;
    tb_do = 1'b1;
    @(negedge clk);
    obs[1] = sdio;
    tb_do = 1'b0;
    @(negedge clk);
    obs[0] = sdio;
    tb_oe = 1'b0;
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    x_data = x; y_data = y; z_data = z;
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] v;
    logic [1:0] z;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({int2, measure} !== 2'b00) begin
      n_bad++; $display("FAIL reset_outputs: int2/measure got %b want 00", {int2, measure});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    probe_z(z);
    n_cmp++;
    if (z !== 2'b10) begin n_bad++; $display("FAIL reset_sdio_z: probe got %b want 10", z); end
    spi_read(6'h2C, v);
    n_cmp++;
    if (v !== 8'h0A) begin n_bad++; $display("FAIL reset_bw_rate: got %h want 0a", v); end
    spi_read(6'h1D, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL reset_0x1d: got %h want 00", v); end
  endtask

  task automatic test_read_devid();
    logic [1:0] z;
    spi_start();
    spi_cmd(8'h80);
    probe_z(z);
    n_cmp++;
    if (z !== 2'b10) begin n_bad++; $display("FAIL devid_z_before_data: probe got %b want 10", z); end
    spi_data(1'b1, 8);
    n_cmp++;
    if (rbuf[0] !== 8'hE5) begin n_bad++; $display("FAIL devid_read: got %h want e5", rbuf[0]); end
    spi_stop();
    probe_z(z);
    n_cmp++;
    if (z !== 2'b10) begin n_bad++; $display("FAIL devid_z_after_csn: probe got %b want 10", z); end
  endtask

  task automatic test_mb0_repeat();
    spi_frame(8'hAC, 16);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (rbuf[i] !== 8'h0A) begin n_bad++; $display("FAIL mb0_byte%0d: got %h want 0a", i, rbuf[i]); end
    end
  endtask

  task automatic test_wrap();
    spi_frame(8'hFF, 16);
    n_cmp++;
    if (rbuf[0] !== 8'h00) begin n_bad++; $display("FAIL wrap_0x3f: got %h want 00", rbuf[0]); end
    n_cmp++;
    if (rbuf[1] !== 8'hE5) begin n_bad++; $display("FAIL wrap_0x00: got %h want e5", rbuf[1]); end
  endtask

  task automatic test_ro_write();
    logic [7:0] v;
    spi_write(6'h00, 8'h12);
    spi_write(6'h30, 8'hFF);
    spi_write(6'h10, 8'h55);
    spi_read(6'h00, v);
    n_cmp++;
    if (v !== 8'hE5) begin n_bad++; $display("FAIL ro_devid: got %h want e5", v); end
    spi_read(6'h30, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL ro_int_source: got %h want 00", v); end
    spi_read(6'h10, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL unmapped_0x10: got %h want 00", v); end
  endtask

  task automatic test_activity_int();
    logic [7:0] v;
    spi_write(6'h2E, 8'h10);
    spi_write(6'h2F, 8'h10);
    n_cmp++;
    if (int2 !== 1'b0) begin n_bad++; $display("FAIL int2_idle: got %b want 0", int2); end
    act_stb = 1'b1;
    @(negedge clk);
    act_stb = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (int2 !== 1'b1) begin n_bad++; $display("FAIL int2_on_activity: got %b want 1", int2); end
    spi_read(6'h30, v);
    n_cmp++;
    if (v !== 8'h10) begin n_bad++; $display("FAIL int_source_activity: got %h want 10", v); end
    n_cmp++;
    if (int2 !== 1'b0) begin n_bad++; $display("FAIL int2_after_clear: got %b want 0", int2); end
  endtask

  task automatic test_sample_burst();
    logic [7:0] v;
    logic [7:0] exp_b [6];
    exp_b = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h0F, 8'h0F};
    pulse_sample(16'hDEAD, 16'hBEEF, 16'hCAFE);  // ignored: not measuring
    spi_read(6'h30, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL standby_no_ready: got %h want 00", v); end
    spi_read(6'h32, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL standby_datax0: got %h want 00", v); end
    spi_write(6'h2D, 8'h08);
    n_cmp++;
    if (measure !== 1'b1) begin n_bad++; $display("FAIL measure_on: got %b want 1", measure); end
    pulse_sample(16'h1234, 16'hABCD, 16'h0F0F);
    spi_read(6'h30, v);
    n_cmp++;
    if (v !== 8'h80) begin n_bad++; $display("FAIL data_ready_set: got %h want 80", v); end
    spi_frame(8'hF2, 48);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (rbuf[i] !== exp_b[i]) begin n_bad++; $display("FAIL burst1_byte%0d: got %h want %h", i, rbuf[i], exp_b[i]); end
    end
    spi_read(6'h30, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL data_ready_clear: got %h want 00", v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic [7:0] old_b [6];
    logic [7:0] new_b [6];
    old_b = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h0F, 8'h0F};
    new_b = '{8'h55, 8'h55, 8'h66, 8'h66, 8'h77, 8'h77};
    fork
      spi_frame(8'hF2, 48);
      begin
        repeat (40*H) @(negedge clk);
        pulse_sample(16'h5555, 16'h6666, 16'h7777);
      end
    join
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (rbuf[i] !== old_b[i]) begin n_bad++; $display("FAIL shadow_old_byte%0d: got %h want %h", i, rbuf[i], old_b[i]); end
    end
    spi_read(6'h30, v);
    n_cmp++;
    if (v !== 8'h80) begin n_bad++; $display("FAIL shadow_ready: got %h want 80", v); end
    spi_frame(8'hF2, 48);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (rbuf[i] !== new_b[i]) begin n_bad++; $display("FAIL shadow_new_byte%0d: got %h want %h", i, rbuf[i], new_b[i]); end
    end
  endtask

  task automatic test_partial_write();
    logic [7:0] v;
    wbuf[0] = 8'hFF;
    spi_frame(8'h24, 4);  // CSN rises after 12 bits
    spi_read(6'h24, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL partial_write_discard: got %h want 00", v); end
    spi_write(6'h24, 8'h20);
    spi_read(6'h24, v);
    n_cmp++;
    if (v !== 8'h20) begin n_bad++; $display("FAIL full_write_0x24: got %h want 20", v); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] v;
    logic [1:0] z;
    spi_start();
    spi_cmd(8'hAD);
    spi_data(1'b1, 4);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (measure !== 1'b0) begin n_bad++; $display("FAIL rst_measure: got %b want 0", measure); end
    probe_z(z);
    n_cmp++;
    if (z !== 2'b10) begin n_bad++; $display("FAIL rst_sdio_z: probe got %b want 10", z); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // Still inside the old frame: this read command must be ignored.
    spi_cmd(8'h80);
    spi_data(1'b1, 3);
    probe_z(z);
    n_cmp++;
    if (z !== 2'b10) begin n_bad++; $display("FAIL ignored_frame_z: probe got %b want 10", z); end
    spi_stop();
    spi_read(6'h2D, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL rst_power_ctl: got %h want 00", v); end
    spi_read(6'h00, v);
    n_cmp++;
    if (v !== 8'hE5) begin n_bad++; $display("FAIL post_rst_devid: got %h want e5", v); end
  endtask

  initial begin
    rst_n      = 1'b0;
    sclk       = 1'b1;
    csn        = 1'b1;
    tb_oe      = 1'b0;
    tb_do      = 1'b0;
    x_data     = 16'd0;
    y_data     = 16'd0;
    z_data     = 16'd0;
    sample_stb = 1'b0;
    act_stb    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = 8'h00;
      rbuf[i] = 8'h00;
    end
    repeat (4) @(negedge clk);

    test_reset();
    test_read_devid();
    test_mb0_repeat();
    test_wrap();
    test_ro_write();
    test_activity_int();
    test_sample_burst();
    test_back_to_back();
    test_partial_write();
    test_reset_mid_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adxl_spi_responder.md
ADXL_SPI_RESPONDER -- requirements
Module: adxl_spi_responder

Interface
REQ-001 Parameter DEVID_VAL, default 8'hE5, value returned on reads of address 0x00.
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop stages on iSPI_SCLK, iSPI_CSN and SPI_SDIO input.
REQ-003 iSPI_CLK  input  1  sole system clock; all state updates on its rising edge.
REQ-004 iRSTN  input  1  reset, asynchronous, active-low.
REQ-005 iSPI_SCLK  input  1  SPI clock from master, mode 3 (idles high).
REQ-006 iSPI_CSN  input  1  chip select from master, active-low.
REQ-007 SPI_SDIO  inout  1  3-wire bidirectional data; driven only during read data phase, else high-Z.
REQ-008 iX_DATA, iY_DATA, iZ_DATA  input  16 each  sensor sample words.
REQ-009 iSAMPLE_STB  input  1  one-cycle pulse: new sample present on iX/iY/iZ_DATA.
REQ-010 iACT_STB  input  1  one-cycle pulse: activity event.
REQ-011 oINT2  output  1  interrupt pin INT2.
REQ-012 oMEASURE  output  1  POWER_CTL bit3 (measure mode).

Function
REQ-013 Inputs pass through SYNC_STAGES synchronizers; edges detected on synchronized SCLK; master SCLK half-period SHALL be >= 4 iSPI_CLK cycles.
REQ-014 Frame: CSN falling starts; bits sampled on SCLK rising, MSB first: bit15 R/W (1=read), bit14 MB, bits13:8 address, then 8-bit data bytes.
REQ-015 FSM states IDLE, CMD, DATA; IDLE->CMD on CSN low; CMD->DATA after 8th rising edge; any state->IDLE on CSN high.
REQ-016 Write: data byte commits to register on its 8th rising edge, +1 cycle; partial bytes discarded.
REQ-017 Read: SDIO output enabled from first SCLK falling edge after 8th command bit; each data bit updated on SCLK falling edge, MSB first, within 2 iSPI_CLK cycles after synchronized edge.
REQ-018 MB=1: address increments by 1 after each completed byte, wrapping 0x3F->0x00; MB=0: further bytes repeat same address.
REQ-019 Map: 0x00 DEVID (RO); 0x1D-0x2F and 0x31 R/W, reset 8'h00 except BW_RATE 0x2C reset 8'h0A; 0x30 INT_SOURCE (RO); 0x32-0x37 DATAX0..DATAZ1 (RO, low byte first); all others read 8'h00, writes ignored.
REQ-020 Shadow data: iSAMPLE_STB loads X/Y/Z into pending buffer; pending copies to visible data registers when CSN high (immediately if idle, else at CSN rising), so a burst never mixes samples.
REQ-021 INT_SOURCE bit7 DATA_READY set when visible data updates; cleared when a read frame reads address 0x32 byte completes.
REQ-022 INT_SOURCE bit4 ACTIVITY set by iACT_STB; cleared on completed read of 0x30; set in same cycle as clear wins (set).
REQ-023 Other INT_SOURCE bits read 0.
REQ-024 oINT2 = OR over bits of (INT_SOURCE & INT_ENABLE & INT_MAP), registered, 1-cycle latency.
REQ-025 oMEASURE = POWER_CTL[3], registered.
REQ-026 iSAMPLE_STB ignored while POWER_CTL[3]=0; iACT_STB always accepted.
REQ-027 CSN high mid-byte: abort, SDIO released within 2 cycles of synchronized CSN, no commit, no address change, no flag clears.

Reset
REQ-028 iRSTN low: FSM IDLE, SDIO high-Z, all registers to REQ-019 values, data and pending buffers 0, INT_SOURCE 0, oINT2=0, oMEASURE=0; effective immediately, including mid-frame.
REQ-029 After iRSTN rises, a frame already in progress (CSN low) SHALL be ignored until CSN returns high.

Verification
REQ-030 Read 0x00 (cmd 8'h80) -> SDIO returns 8'hE5, high-Z before bit 7 and after CSN high.
REQ-031 Write 0x2E=8'h10, 0x2F=8'h10, then iACT_STB -> oINT2=1 next cycle; read 0x30 returns 8'h10 -> oINT2=0 after frame.
REQ-032 Write 0x2D=8'h08; iSAMPLE_STB with X=16'h1234,Y=16'hABCD,Z=16'h0F0F; MB burst read from 0x32 -> 34 12 CD AB 0F 0F; DATA_READY cleared.
REQ-033 iSAMPLE_STB with new X=16'h5555 during burst -> burst returns old sample; next burst returns 55 55.
REQ-034 Write 0x24 with CSN high after 12 bits -> 0x24 reads 8'h00; subsequent full write 8'h20 reads back 8'h20.
REQ-035 Assert iRSTN low during read data phase -> SDIO high-Z, 0x2D reads 8'h00, oMEASURE=0.
